light_sequencer: RTL and testbench

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_sequencer.sv | 132 +++++++++++++
 tb/tb_light_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// Lamp mode sequencer: steps through lighting modes on button pulses and animates the LEDs on beat ticks.
// Optional CHASE mode is built only when LIGHT_SEQ_CHASE_EN is defined.
module light_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_btn,
    input  logic       tick,
    output logic [8:0] load_value,
    output logic       timer_restart,
    output logic [2:0] mode,
    output logic [3:0] leds
);

`ifdef LIGHT_SEQ_CHASE_EN
    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_SOLID  = 3'd1,
        MODE_BLINK  = 3'd2,
        MODE_STROBE = 3'd3,
        MODE_CHASE  = 3'd4
    } mode_e;
`else
    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_SOLID  = 3'd1,
        MODE_BLINK  = 3'd2,
        MODE_STROBE = 3'd3
    } mode_e;
`endif

    mode_e      mode_q, mode_d;
    logic [2:0] step_q, step_d;
    logic [8:0] load_q, load_d;
    logic       restart_q, restart_d;
    logic [3:0] leds_q, leds_d;

    mode_e      nextMode;
    logic       stepCounts;

    function automatic logic [8:0] loadFor(input mode_e m);
        logic [8:0] v;
        v = 9'd32;
        case (m)
            MODE_BLINK:  v = 9'd16;
            MODE_STROBE: v = 9'd4;
`ifdef LIGHT_SEQ_CHASE_EN
            MODE_CHASE:  v = 9'd8;
`endif
            default:     v = 9'd32;
        endcase
        return v;
    endfunction

    always_comb begin
        nextMode   = MODE_OFF;
        stepCounts = 1'b0;
        case (mode_q)
            MODE_OFF:    nextMode = MODE_SOLID;
            MODE_SOLID:  nextMode = MODE_BLINK;
            MODE_BLINK: begin
                nextMode   = MODE_STROBE;
                stepCounts = 1'b1;
            end
            MODE_STROBE: begin
`ifdef LIGHT_SEQ_CHASE_EN
                nextMode   = MODE_CHASE;
`else
                nextMode   = MODE_OFF;
`endif
                stepCounts = 1'b1;
            end
`ifdef LIGHT_SEQ_CHASE_EN
            MODE_CHASE: begin
                nextMode   = MODE_OFF;
                stepCounts = 1'b1;
            end
`endif
            default:     nextMode = MODE_OFF;
        endcase
    end

    // A button pulse wins over a coincident tick; ticks during the restart cycle are dropped.
    always_comb begin
        mode_d    = mode_q;
        step_d    = step_q;
        load_d    = load_q;
        restart_d = 1'b0;
        if (mode_btn) begin
            mode_d    = nextMode;
            step_d    = 3'd0;
            load_d    = loadFor(nextMode);
            restart_d = 1'b1;
        end else if (tick && !restart_q && stepCounts) begin
            step_d = step_q + 3'd1;
        end
    end

    always_comb begin
        leds_d = 4'b0000;
        case (mode_q)
            MODE_SOLID:  leds_d = 4'b1111;
            MODE_BLINK:  leds_d = step_q[0] ? 4'b0000 : 4'b1111;
            MODE_STROBE: leds_d = (step_q == 3'd0 || step_q == 3'd2) ? 4'b1111 : 4'b0000;
`ifdef LIGHT_SEQ_CHASE_EN
            MODE_CHASE:  leds_d = 4'b0001 << step_q[1:0];
`endif
            default:     leds_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_OFF;
            step_q    <= 3'd0;
            load_q    <= 9'd32;
            restart_q <= 1'b0;
            leds_q    <= 4'b0000;
        end else begin
            mode_q    <= mode_d;
            step_q    <= step_d;
            load_q    <= load_d;
            restart_q <= restart_d;
            leds_q    <= leds_d;
        end
    end

    assign mode          = mode_q;
    assign load_value    = load_q;
    assign timer_restart = restart_q;
    assign leds          = leds_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer: vector table, hand-written corner sequences and a random run
// compared against a behavioural model.
module tb_light_sequencer;

    logic       clk;
    logic       reset_n;
    logic       mode_btn;
    logic       tick;
    logic [8:0] load_value;
    logic       timer_restart;
    logic [2:0] mode;
    logic [3:0] leds;

    int assertCount;
    int failCount;

    int mMode;
    int mStep;
    int mRestart;
    int mLeds;

`ifdef LIGHT_SEQ_CHASE_EN
    localparam int NUM_MODES = 5;
`else
    localparam int NUM_MODES = 4;
`endif

    typedef struct {
        int btn;
        int tk;
        int eMode;
        int eLoad;
        int eRestart;
        int eLeds;
    } vec_t;

    vec_t vecs[11];

    light_sequencer dut (
        .clk(clk),
        .reset_n(reset_n),
        .mode_btn(mode_btn),
        .tick(tick),
        .load_value(load_value),
        .timer_restart(timer_restart),
        .mode(mode),
        .leds(leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int loadOf(input int m);
        case (m)
            2: return 16;
            3: return 4;
            4: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int ledsOf(input int m, input int s);
        case (m)
            1: return 15;
            2: return (s % 2 == 0) ? 15 : 0;
            3: return (s == 0 || s == 2) ? 15 : 0;
            4: return 1 << (s % 4);
            default: return 0;
        endcase
    endfunction

    task automatic modelReset();
        mMode = 0; mStep = 0; mRestart = 0; mLeds = 0;
    endtask

    // LEDs reflect the mode/step held before the edge, hence computed first.
    task automatic modelStep(input int btn, input int tk);
        int newLeds;
        newLeds = ledsOf(mMode, mStep);
        if (btn != 0) begin
            mMode = (mMode + 1) % NUM_MODES;
            mStep = 0;
            mRestart = 1;
        end else begin
            if (tk != 0 && mRestart == 0 && mMode >= 2) mStep = (mStep + 1) % 8;
            mRestart = 0;
        end
        mLeds = newLeds;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int btn, input int tk);
        mode_btn = (btn != 0);
        tick     = (tk != 0);
        @(posedge clk);
        #1;
        mode_btn = 1'b0;
        tick     = 1'b0;
        modelStep(btn, tk);
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".mode"}, int'(mode), mMode);
        checkOutput({tag, ".load"}, int'(load_value), loadOf(mMode));
        checkOutput({tag, ".restart"}, int'(timer_restart), mRestart);
        checkOutput({tag, ".leds"}, int'(leds), mLeds);
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst.mode", int'(mode), 0);
        checkOutput("rst.load", int'(load_value), 32);
        checkOutput("rst.restart", int'(timer_restart), 0);
        checkOutput("rst.leds", int'(leds), 0);
        reset_n = 1'b1;
        modelReset();
    endtask

    initial begin
        int strobePat[8];
        int chasePat[5];
        assertCount = 0;
        failCount   = 0;
        mode_btn    = 1'b0;
        tick        = 1'b0;
        reset_n     = 1'b1;
        modelReset();

        strobePat = '{15, 0, 15, 0, 0, 0, 0, 0};
        chasePat  = '{1, 2, 4, 8, 1};

        vecs[0]  = '{1, 0, 1, 32, 1, 0};
        vecs[1]  = '{0, 1, 1, 32, 0, 15};
        vecs[2]  = '{0, 1, 1, 32, 0, 15};
        vecs[3]  = '{1, 0, 2, 16, 1, 15};
        vecs[4]  = '{0, 1, 2, 16, 0, 15};
        vecs[5]  = '{0, 1, 2, 16, 0, 15};
        vecs[6]  = '{0, 0, 2, 16, 0, 0};
        vecs[7]  = '{0, 1, 2, 16, 0, 0};
        vecs[8]  = '{0, 0, 2, 16, 0, 15};
        vecs[9]  = '{1, 0, 3, 4, 1, 15};
        vecs[10] = '{0, 0, 3, 4, 0, 15};

        #3;
        doReset();

        // Ticks in OFF leave the lamps dark.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1);
            checkOutput("off.leds", int'(leds), 0);
            checkOutput("off.mode", int'(mode), 0);
        end

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].btn, vecs[i].tk);
            checkOutput($sformatf("vec%0d.mode", i), int'(mode), vecs[i].eMode);
            checkOutput($sformatf("vec%0d.load", i), int'(load_value), vecs[i].eLoad);
            checkOutput($sformatf("vec%0d.restart", i), int'(timer_restart), vecs[i].eRestart);
            checkOutput($sformatf("vec%0d.leds", i), int'(leds), vecs[i].eLeds);
        end

        // STROBE pattern over a full step wrap.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1);
            checkOutput($sformatf("strobe.t%0d", k + 1), int'(leds), strobePat[k]);
        end
        applyStimulus(0, 0);
        checkOutput("strobe.wrap", int'(leds), 15);

        // Two pulses from OFF, then BLINK animation, then async reset mid-BLINK with leds lit.
        doReset();
        applyStimulus(1, 0);
        checkOutput("two.r1", int'(timer_restart), 1);
        applyStimulus(1, 0);
        checkOutput("two.r2", int'(timer_restart), 1);
        checkOutput("two.mode", int'(mode), 2);
        checkOutput("two.load", int'(load_value), 16);
        applyStimulus(0, 0);
        checkOutput("two.r3", int'(timer_restart), 0);
        applyStimulus(0, 1);
        checkOutput("blink.t1", int'(leds), 15);
        applyStimulus(0, 1);
        checkOutput("blink.t2", int'(leds), 0);
        applyStimulus(0, 1);
        checkOutput("blink.t3", int'(leds), 15);
        checkOutput("blink.pre", int'(mode), 2);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async.leds", int'(leds), 0);
        checkOutput("async.mode", int'(mode), 0);
        checkOutput("async.load", int'(load_value), 32);
        checkOutput("async.restart", int'(timer_restart), 0);
        #3;
        reset_n = 1'b1;
        modelReset();

        // Button and tick together in BLINK step 3: tick must be discarded.
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        checkOutput("coin.mode", int'(mode), 3);
        checkOutput("coin.load", int'(load_value), 4);
        checkOutput("coin.restart", int'(timer_restart), 1);
        checkOutput("coin.leds", int'(leds), 0);
        applyStimulus(0, 0);
        checkOutput("coin.step0a", int'(leds), 15);
        applyStimulus(0, 0);
        checkOutput("coin.step0b", int'(leds), 15);
        applyStimulus(0, 1);
        applyStimulus(0, 0);
        checkOutput("coin.step1", int'(leds), 0);

        // Four pulses from OFF.
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1, 0);
`ifdef LIGHT_SEQ_CHASE_EN
        checkOutput("four.mode", int'(mode), 4);
        checkOutput("four.load", int'(load_value), 8);
        applyStimulus(0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1);
            checkOutput($sformatf("chase.t%0d", k + 1), int'(leds), chasePat[k]);
        end
`else
        checkOutput("four.mode", int'(mode), 0);
        checkOutput("four.load", int'(load_value), 32);
        checkOutput("four.restart", int'(timer_restart), 1);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        checkOutput("four.leds", int'(leds), 0);
`endif

        // SOLID ignores ticks.
        doReset();
        applyStimulus(1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1);
            checkOutput("solid.leds", int'(leds), 15);
            checkOutput("solid.mode", int'(mode), 1);
        end

        // Random run against the behavioural model.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 11) == 0) ? 1 : 0, int'($urandom_range(0, 1)));
            checkModel("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
